// File: rtl/mul_add_8bit_if.sv
// Operand/result bundle for mul_add_8bit: in_valid start strobe with operands in,
// one-cycle out_valid result strobe with the reconstructed dividend and flags out.
interface mul_add_8bit_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   remainder;
  logic               out_valid;
  logic [2*WIDTH-1:0] dividend;
  logic               ovf;
  logic               rem_err;

  modport master (
    output in_valid, quotient, divisor, remainder,
    input  out_valid, dividend, ovf, rem_err
  );

  modport slave (
    input  in_valid, quotient, divisor, remainder,
    output out_valid, dividend, ovf, rem_err
  );
endinterface

// File: rtl/mul_add_8bit.sv
// Iterative shift-add reconstructor: dividend = quotient*divisor + remainder, one quotient bit per clock.
// Optional MULADD_EARLY_EXIT_EN ends CALC once no multiplier 1-bits remain (results unchanged).
module mul_add_8bit #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mul_add_8bit_if.slave   bus
);

  localparam int          PW       = 2 * WIDTH;
  localparam logic [2:0]  CNT_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [PW-1:0]     acc;
  logic [PW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic [2:0]        cnt;
  logic              rem_err_r;

  logic [PW-1:0]     dividend_r;
  logic              ovf_r;
  logic              rem_err_o;
  logic              out_valid_r;

  logic [PW-1:0]     acc_sum;
  logic [WIDTH-1:0]  mplier_sh;
  logic              last;
  logic              load;
  logic              finish;

  function automatic logic [PW-1:0] add_step(input logic [PW-1:0] a,
                                             input logic [PW-1:0] m,
                                             input logic          bit0);
    // Max 255*255+255 fits in 16 bits, so the sum never wraps.
    return bit0 ? (a + m) : a;
  endfunction

  function automatic logic upper_nonzero(input logic [PW-1:0] v);
    return |v[PW-1:WIDTH];
  endfunction

  assign acc_sum   = add_step(acc, mcand, mplier[0]);
  assign mplier_sh = mplier >> 1;

`ifdef MULADD_EARLY_EXIT_EN
  assign last = (cnt == CNT_LAST) || (mplier_sh == '0);
`else
  assign last = (cnt == CNT_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DONE also samples in_valid so back-to-back operations run every 9 cycles.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.in_valid) begin
          load      = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      rem_err_r <= 1'b0;
    end else if (load) begin
      acc       <= {{WIDTH{1'b0}}, bus.remainder};
      mcand     <= {{WIDTH{1'b0}}, bus.divisor};
      mplier    <= bus.quotient;
      cnt       <= '0;
      rem_err_r <= (bus.remainder >= bus.divisor);
    end else if (state == CALC) begin
      acc       <= acc_sum;
      mcand     <= mcand << 1;
      mplier    <= mplier_sh;
      cnt       <= cnt + 3'd1;
    end
  end

  // Result registers hold until the next finishing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_r  <= '0;
      ovf_r       <= 1'b0;
      rem_err_o   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= finish;
      if (finish) begin
        dividend_r <= acc_sum;
        ovf_r      <= upper_nonzero(acc_sum);
        rem_err_o  <= rem_err_r;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.dividend  = dividend_r;
  assign bus.ovf       = ovf_r;
  assign bus.rem_err   = rem_err_o;

endmodule

// File: tb/tb_mul_add_8bit.sv
// Randomized self-checking bench for mul_add_8bit against an arithmetic reference model.
// Latency expectations follow MULADD_EARLY_EXIT_EN when it is defined.
module tb_mul_add_8bit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mul_add_8bit_if #(.WIDTH(8)) bus();

  mul_add_8bit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] q);
    int l;
    l = 8;
`ifdef MULADD_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < 8; i++) if (q[i]) l = i + 1;
`endif
    return l;
  endfunction

  task automatic run_op(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r,
                        input string tag, output logic [15:0] got);
    int          lat;
    bit          seen;
    int unsigned ref_val;
    ref_val = int'(q) * int'(d) + int'(r);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.quotient  = q;
    bus.divisor   = d;
    bus.remainder = r;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.quotient  = 8'($urandom);
    bus.divisor   = 8'($urandom);
    bus.remainder = 8'($urandom);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check({tag, " latency"}, lat, exp_lat(q));
    check({tag, " dividend"}, bus.dividend, ref_val);
    check({tag, " ovf"}, bus.ovf, (ref_val > 255) ? 1 : 0);
    check({tag, " rem_err"}, bus.rem_err, (r >= d) ? 1 : 0);
    got = bus.dividend;
    @(posedge clk);
    #1;
    check({tag, " out_valid drop"}, bus.out_valid, 0);
    check({tag, " dividend hold"}, bus.dividend, ref_val);
  endtask

  initial begin
    logic [15:0] got;
    int          a, dd, nxt, pulses, exp_pulses, lat2;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.quotient  = '0;
    bus.divisor   = '0;
    bus.remainder = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", bus.out_valid, 0);
    check("reset dividend", bus.dividend, 0);
    check("reset ovf", bus.ovf, 0);
    check("reset rem_err", bus.rem_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_op(8'd12, 8'd20, 8'd7, "basic", got);
    run_op(8'd255, 8'd255, 8'd254, "max", got);
    run_op(8'd3, 8'd5, 8'd5, "rem_eq_div", got);
    run_op(8'd9, 8'd0, 8'd0, "div_zero", got);
    run_op(8'd0, 8'd77, 8'd13, "q_zero", got);
    run_op(8'd128, 8'd2, 8'd1, "q_msb", got);
    run_op(8'd1, 8'd9, 8'd0, "q_one", got);

    // in_valid held high: back-to-back operations every lat+1 edges
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.quotient  = 8'd2;
    bus.divisor   = 8'd3;
    bus.remainder = 8'd1;
    lat2       = exp_lat(8'd2);
    nxt        = lat2;
    pulses     = 0;
    exp_pulses = 0;
    for (int k = lat2; k < 20; k += lat2 + 1) exp_pulses++;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        pulses++;
        check($sformatf("hold pulse edge %0d", pulses), k, nxt);
        check($sformatf("hold pulse dividend %0d", pulses), bus.dividend, 7);
        nxt += lat2 + 1;
      end
    end
    bus.in_valid = 1'b0;
    check("hold pulse count", pulses, exp_pulses);
    repeat (12) @(posedge clk);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.quotient  = 8'd100;
    bus.divisor   = 8'd2;
    bus.remainder = 8'd0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", bus.out_valid, 0);
    check("midreset dividend", bus.dividend, 0);
    check("midreset ovf", bus.ovf, 0);
    check("midreset rem_err", bus.rem_err, 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) pulses++;
    end
    check("post-reset spurious out_valid", pulses, 0);
    run_op(8'd100, 8'd2, 8'd0, "after_reset", got);

    // round trip against integer division
    for (int n = 0; n < 10; n++) begin
      a  = int'($urandom_range(0, 255));
      dd = int'($urandom_range(1, 255));
      run_op(8'(a / dd), 8'(dd), 8'(a % dd), $sformatf("roundtrip%0d", n), got);
      check($sformatf("roundtrip%0d low byte", n), got[7:0], a);
    end

    for (int n = 0; n < 10; n++) begin
      run_op(8'($urandom), 8'($urandom), 8'($urandom), $sformatf("rand%0d", n), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
